// File: rtl/data_in_w_to_n.sv
// Splits IN_W-bit words into OUT_W-bit groups, one group per request edge,
// with a single holding buffer behind the active word for back-to-back words.
module data_in_w_to_n #(
    parameter  int IN_W      = 64,
    parameter  int OUT_W     = 8,
    parameter  int MSB_FIRST = 0,
    localparam int GROUPS    = IN_W / OUT_W,
    localparam int IDX_W     = $clog2(GROUPS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [IN_W-1:0]    data_in,
    input  logic               data_in_valid,
    output logic               data_in_ready,
    input  logic               tx_req,
    input  logic               manual_start,
    input  logic               err_clr,
    output logic [OUT_W-1:0]   data_out,
    output logic               tx_enable,
    output logic [IDX_W-1:0]   group_idx,
    output logic               last_group,
    output logic               busy,
    output logic               underrun
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(GROUPS - 1);

    logic                           r_tx_req_d;
    logic                           r_manual_start_d;
    logic                           r_pend;
    logic [IN_W-1:0]                r_active;
    logic [IN_W-1:0]                r_hold;
    logic                           r_active_valid;
    logic                           r_hold_full;
    logic [OUT_W-1:0]               r_data_out;
    logic [IDX_W-1:0]               r_group_idx;
    logic                           r_tx_enable;
    logic                           r_underrun;

    logic                           w_edge;
    logic                           w_req;
    logic                           w_remaining;
    logic                           w_accept;
    logic                           w_advance;
    logic                           w_load;
    logic                           w_underrun_evt;
    logic [IDX_W-1:0]               w_next_idx;
    logic [IDX_W-1:0]               w_sel;
    logic [GROUPS-1:0][OUT_W-1:0]   w_active_groups;
    logic [OUT_W-1:0]               w_adv_group;
    logic [OUT_W-1:0]               w_hold_group0;

    logic                           w_pend_nxt;
    logic                           w_active_valid_nxt;
    logic                           w_hold_full_nxt;
    logic [OUT_W-1:0]               w_data_out_nxt;
    logic [IDX_W-1:0]               w_group_idx_nxt;
    logic                           w_underrun_nxt;

    // Simultaneous edges merge into one event; an edge landing on a tx_enable
    // cycle is parked in r_pend so pulses are never back to back.
    assign w_edge = (tx_req & ~r_tx_req_d) | (manual_start & ~r_manual_start_d);
    assign w_req  = (w_edge | r_pend) & ~r_tx_enable;

    assign w_remaining    = r_active_valid && (r_group_idx != LAST_IDX);
    assign w_accept       = data_in_valid && !r_hold_full;
    assign w_advance      = w_req && w_remaining;
    assign w_load         = w_req && !w_remaining && r_hold_full;
    assign w_underrun_evt = w_req && !w_remaining && !r_hold_full;

    assign w_next_idx      = r_group_idx + 1'b1;
    assign w_sel           = (MSB_FIRST != 0) ? (LAST_IDX - w_next_idx) : w_next_idx;
    assign w_active_groups = r_active;
    assign w_adv_group     = w_active_groups[w_sel];
    assign w_hold_group0   = (MSB_FIRST != 0) ? r_hold[IN_W-1 -: OUT_W] : r_hold[OUT_W-1:0];

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a latch.
        w_pend_nxt         = (w_edge | r_pend) & r_tx_enable;
        w_active_valid_nxt = r_active_valid;
        w_hold_full_nxt    = r_hold_full;
        w_data_out_nxt     = r_data_out;
        w_group_idx_nxt    = r_group_idx;
        w_underrun_nxt     = r_underrun;

        if (w_advance) begin
            w_data_out_nxt  = w_adv_group;
            w_group_idx_nxt = w_next_idx;
        end else if (w_load) begin
            w_data_out_nxt     = w_hold_group0;
            w_group_idx_nxt    = '0;
            w_active_valid_nxt = 1'b1;
        end

        // Acceptance needs an empty buffer and a load needs a full one, so
        // they never coincide; a request this cycle only sees the old state.
        if (w_accept) begin
            w_hold_full_nxt = 1'b1;
        end else if (w_load) begin
            w_hold_full_nxt = 1'b0;
        end

        if (w_underrun_evt) begin
            w_underrun_nxt = 1'b1;
        end else if (err_clr) begin
            w_underrun_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_req_d       <= 1'b0;
            r_manual_start_d <= 1'b0;
            r_pend           <= 1'b0;
            r_active_valid   <= 1'b0;
            r_hold_full      <= 1'b0;
            r_data_out       <= '0;
            r_group_idx      <= '0;
            r_tx_enable      <= 1'b0;
            r_underrun       <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            r_tx_req_d       <= tx_req;
            r_manual_start_d <= manual_start;
            r_pend           <= w_pend_nxt;
            r_active_valid   <= w_active_valid_nxt;
            r_hold_full      <= w_hold_full_nxt;
            r_data_out       <= w_data_out_nxt;
            r_group_idx      <= w_group_idx_nxt;
            r_tx_enable      <= w_advance | w_load;
            r_underrun       <= w_underrun_nxt;
        end
    end

    // NOTE: word payloads carry no reset; their valid/full flags gate every use.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_hold <= data_in;
        end
        if (w_load) begin
            r_active <= r_hold;
        end
    end

    assign data_in_ready = ~r_hold_full;
    assign data_out      = r_data_out;
    assign tx_enable     = r_tx_enable;
    assign group_idx     = r_group_idx;
    assign last_group    = r_active_valid && (r_group_idx == LAST_IDX);
    assign busy          = w_remaining || r_hold_full;
    assign underrun      = r_underrun;

endmodule
